// File: rtl/usb_rx_pkg.sv
// Shared constants and types for the USB RX deserialiser.
//   USB_SYNC_BYTE      : SYNC word as seen LSB-first on the wire (8'h80)
//   rx_deser_state_t   : word-alignment state (HUNT / ALIGNED)
//   DEFAULT_DATA_WIDTH : default bits per assembled word
//   DEFAULT_CNT_WIDTH  : default width of the per-packet word counter
package usb_rx_pkg;

  localparam int         DEFAULT_DATA_WIDTH = 8;
  localparam int         DEFAULT_CNT_WIDTH  = 7;
  localparam logic [7:0] USB_SYNC_BYTE      = 8'h80;

  typedef enum logic {
    HUNT    = 1'b0,
    ALIGNED = 1'b1
  } rx_deser_state_t;

endpackage

// File: rtl/rx_bit_counter.sv
// Rollover counter with enable and synchronous clear.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   clear         : synchronous clear to 0 (priority over enable)
//   enable        : advance the count this cycle
//   rollover_val  : terminal value; the count after it is 0
//   count         : current count
//   rollover_flag : high in the cycle an enabled advance wraps from
//                   rollover_val back to 0 (combinational)
module rx_bit_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] rollover_val,
  output logic [WIDTH-1:0] count,
  output logic             rollover_flag
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d       = count_q;
    rollover_flag = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      if (count_q == rollover_val) begin
        count_d       = '0;
        rollover_flag = 1'b1;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/usb_rx_deser.sv
// Serial-to-parallel deserialiser for the USB RX datapath. Takes decoded,
// de-stuffed bits (one per shift_enable cycle) and assembles DATA_WIDTH-bit
// words, announcing each completed word with a one-cycle word_ready pulse.
// Build option: define USB_RX_SYNC_DETECT_EN to add a HUNT/ALIGNED stage that
// discards bits until the shift register matches SYNC_PATTERN. Without it the
// block is permanently aligned and sync_found is tied low.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   d_orig       : decoded serial bit, sampled when shift_enable=1
//   shift_enable : a valid bit is present this cycle
//   clear        : packet restart (EOP/abort), discards the bit in its cycle
//   packet_data  : last completed word, held until the next completion
//   word_ready   : one-cycle pulse, packet_data updated in the same cycle
//   word_count   : words completed since clear/rst, saturating
//   bit_count    : bits held in the current partial word
//   partial_err  : one-cycle pulse when clear hits a partial word
//   sync_found   : one-cycle pulse on SYNC match
module usb_rx_deser
  import usb_rx_pkg::*;
#(
  parameter int                    DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int                    MSB_FIRST    = 0,
  parameter int                    CNT_WIDTH    = DEFAULT_CNT_WIDTH,
  parameter logic [DATA_WIDTH-1:0] SYNC_PATTERN = DATA_WIDTH'(USB_SYNC_BYTE)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          d_orig,
  input  logic                          shift_enable,
  input  logic                          clear,
  output logic [DATA_WIDTH-1:0]         packet_data,
  output logic                          word_ready,
  output logic [CNT_WIDTH-1:0]          word_count,
  output logic [$clog2(DATA_WIDTH)-1:0] bit_count,
  output logic                          partial_err,
  output logic                          sync_found
);

  localparam int BC_W = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] sr_q, sr_d, sr_shift;
  logic [DATA_WIDTH-1:0] packet_data_q, packet_data_d;
  logic [CNT_WIDTH-1:0]  word_count_q, word_count_d;
  logic                  word_ready_q, word_ready_d;
  logic                  partial_err_q, partial_err_d;
  logic [BC_W-1:0]       bit_count_w;
  logic                  word_done;
  logic                  aligned;

  // Shift direction decides where the first received bit ends up.
  generate
    if (MSB_FIRST == 0) begin : g_lsb_first
      assign sr_shift = {d_orig, sr_q[DATA_WIDTH-1:1]};
    end else begin : g_msb_first
      assign sr_shift = {sr_q[DATA_WIDTH-2:0], d_orig};
    end
  endgenerate

`ifdef USB_RX_SYNC_DETECT_EN
  rx_deser_state_t state_q, state_d;
  logic            sync_found_q, sync_found_d;
  assign aligned = (state_q == ALIGNED);
`else
  // No alignment stage: every bit belongs to a word.
  logic unused_sync_pattern;
  assign aligned             = 1'b1;
  assign unused_sync_pattern = ^SYNC_PATTERN;
`endif

  // Bit position within the word. Held at 0 while hunting so the first word
  // after SYNC starts cleanly; word_done fires on the last bit of a word.
  rx_bit_counter #(
    .WIDTH (BC_W)
  ) u_bit_counter (
    .clk           (clk),
    .rst           (rst),
    .clear         (clear),
    .enable        (shift_enable & aligned & ~clear),
    .rollover_val  (BC_W'(DATA_WIDTH - 1)),
    .count         (bit_count_w),
    .rollover_flag (word_done)
  );

  always_comb begin
    sr_d          = sr_q;
    packet_data_d = packet_data_q;
    word_count_d  = word_count_q;
    word_ready_d  = 1'b0;
    partial_err_d = 1'b0;
`ifdef USB_RX_SYNC_DETECT_EN
    state_d       = state_q;
    sync_found_d  = 1'b0;
`endif
    if (clear) begin
      // The bit arriving with clear is dropped; packet_data is kept.
      sr_d          = '0;
      word_count_d  = '0;
      partial_err_d = (bit_count_w != '0);
`ifdef USB_RX_SYNC_DETECT_EN
      state_d       = HUNT;
`endif
    end else if (shift_enable) begin
      sr_d = sr_shift;
      if (word_done) begin
        packet_data_d = sr_shift;
        word_ready_d  = 1'b1;
        if (word_count_q != {CNT_WIDTH{1'b1}}) begin
          word_count_d = word_count_q + CNT_WIDTH'(1);
        end
      end
`ifdef USB_RX_SYNC_DETECT_EN
      // The SYNC word only aligns; it is neither published nor counted.
      if (!aligned && (sr_shift == SYNC_PATTERN)) begin
        state_d      = ALIGNED;
        sync_found_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q          <= '0;
      packet_data_q <= '0;
      word_count_q  <= '0;
      word_ready_q  <= 1'b0;
      partial_err_q <= 1'b0;
`ifdef USB_RX_SYNC_DETECT_EN
      state_q       <= HUNT;
      sync_found_q  <= 1'b0;
`endif
    end else begin
      sr_q          <= sr_d;
      packet_data_q <= packet_data_d;
      word_count_q  <= word_count_d;
      word_ready_q  <= word_ready_d;
      partial_err_q <= partial_err_d;
`ifdef USB_RX_SYNC_DETECT_EN
      state_q       <= state_d;
      sync_found_q  <= sync_found_d;
`endif
    end
  end

  assign packet_data = packet_data_q;
  assign word_ready  = word_ready_q;
  assign word_count  = word_count_q;
  assign bit_count   = bit_count_w;
  assign partial_err = partial_err_q;
`ifdef USB_RX_SYNC_DETECT_EN
  assign sync_found  = sync_found_q;
`else
  assign sync_found  = 1'b0;
`endif

endmodule

// File: tb/tb_usb_rx_deser.sv
// Bench for usb_rx_deser: three instances share one input stream
// (LSB-first CNT_WIDTH=7, MSB-first CNT_WIDTH=7, LSB-first CNT_WIDTH=3) and
// are compared every cycle against a bit-list reference model.
module tb_usb_rx_deser;

  localparam int W = 8;

`ifdef USB_RX_SYNC_DETECT_EN
  localparam bit SYNC_EN = 1'b1;
`else
  localparam bit SYNC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, d_orig, shift_enable, clear;

  logic [7:0] pd0, pd1, pd2;
  logic       wr0, wr1, wr2;
  logic [6:0] wc0, wc1;
  logic [2:0] wc2;
  logic [2:0] bc0, bc1, bc2;
  logic       pe0, pe1, pe2;
  logic       sf0, sf1, sf2;

  usb_rx_deser #(.DATA_WIDTH(8), .MSB_FIRST(0), .CNT_WIDTH(7)) dut_lsb (
    .clk(clk), .rst(rst), .d_orig(d_orig), .shift_enable(shift_enable), .clear(clear),
    .packet_data(pd0), .word_ready(wr0), .word_count(wc0), .bit_count(bc0),
    .partial_err(pe0), .sync_found(sf0));

  usb_rx_deser #(.DATA_WIDTH(8), .MSB_FIRST(1), .CNT_WIDTH(7)) dut_msb (
    .clk(clk), .rst(rst), .d_orig(d_orig), .shift_enable(shift_enable), .clear(clear),
    .packet_data(pd1), .word_ready(wr1), .word_count(wc1), .bit_count(bc1),
    .partial_err(pe1), .sync_found(sf1));

  usb_rx_deser #(.DATA_WIDTH(8), .MSB_FIRST(0), .CNT_WIDTH(3)) dut_sat (
    .clk(clk), .rst(rst), .d_orig(d_orig), .shift_enable(shift_enable), .clear(clear),
    .packet_data(pd2), .word_ready(wr2), .word_count(wc2), .bit_count(bc2),
    .partial_err(pe2), .sync_found(sf2));

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: per instance, the list of bits received in the current
  // word, a window of the last W bits while hunting, and an unbounded word tally.
  int msb_of[3]  = '{0, 1, 0};
  int cmax_of[3] = '{127, 127, 7};
  int cnt[3];
  int bits[3][W];
  int hist[3][W];
  bit hunting[3];
  int total[3];
  int exp_pd[3];
  bit exp_wr[3], exp_pe[3], exp_sf[3];

  function automatic int assemble(input int c, input bit from_hist);
    int v = 0;
    for (int i = 0; i < W; i++) begin
      int b   = from_hist ? hist[c][i] : bits[c][i];
      int pos = (msb_of[c] != 0) ? (W - 1 - i) : i;
      v = v | (b << pos);
    end
    return v;
  endfunction

  task automatic restart(input int c);
    cnt[c]     = 0;
    total[c]   = 0;
    hunting[c] = SYNC_EN;
    for (int i = 0; i < W; i++) hist[c][i] = 0;
  endtask

  task automatic model_edge(input bit r, input bit s, input bit d, input bit cl);
    for (int c = 0; c < 3; c++) begin
      exp_wr[c] = 0;
      exp_pe[c] = 0;
      exp_sf[c] = 0;
      if (r) begin
        restart(c);
        exp_pd[c] = 0;
      end else if (cl) begin
        exp_pe[c] = (cnt[c] != 0);
        restart(c);
      end else if (s) begin
        if (hunting[c]) begin
          for (int i = 0; i < W - 1; i++) hist[c][i] = hist[c][i+1];
          hist[c][W-1] = int'(d);
          if (assemble(c, 1'b1) == 'h80) begin
            hunting[c] = 0;
            exp_sf[c]  = 1;
          end
        end else begin
          bits[c][cnt[c]] = int'(d);
          cnt[c]++;
          if (cnt[c] == W) begin
            exp_pd[c] = assemble(c, 1'b0);
            exp_wr[c] = 1;
            cnt[c]    = 0;
            total[c]++;
          end
        end
      end
    end
  endtask

  task automatic check_cfg(input int c, input logic [7:0] pd, input logic wr,
                           input logic [6:0] wc, input logic [2:0] bc,
                           input logic pe, input logic sf);
    int ewc = (total[c] > cmax_of[c]) ? cmax_of[c] : total[c];
    check_eq($sformatf("packet_data%0d", c), 32'(pd), 32'(exp_pd[c]));
    check_eq($sformatf("word_ready%0d", c),  32'(wr), 32'(exp_wr[c]));
    check_eq($sformatf("word_count%0d", c),  32'(wc), 32'(ewc));
    check_eq($sformatf("bit_count%0d", c),   32'(bc), 32'(cnt[c]));
    check_eq($sformatf("partial_err%0d", c), 32'(pe), 32'(exp_pe[c]));
    check_eq($sformatf("sync_found%0d", c),  32'(sf), 32'(exp_sf[c]));
  endtask

  task automatic step(input bit r, input bit s, input bit d, input bit cl);
    rst          = r;
    shift_enable = s;
    d_orig       = d;
    clear        = cl;
    @(posedge clk);
    model_edge(r, s, d, cl);
    #1;
    check_cfg(0, pd0, wr0, wc0, bc0, pe0, sf0);
    check_cfg(1, pd1, wr1, wc1, bc1, pe1, sf1);
    check_cfg(2, pd2, wr2, 7'(wc2), bc2, pe2, sf2);
  endtask

  // Sends a byte on consecutive cycles, bit 0 first.
  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, b[i], 1'b0);
  endtask

  initial begin
    rst = 1'b1; shift_enable = 1'b0; d_orig = 1'b0; clear = 1'b0;
    for (int c = 0; c < 3; c++) begin
      restart(c);
      exp_pd[c] = 0;
    end

    // Reset with random activity on the data inputs.
    for (int i = 0; i < 2; i++) step(1'b1, 1'($urandom), 1'($urandom), 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // SYNC followed by a data byte (plain data in the default build).
    send_byte(8'h80);
    send_byte(8'h3C);

    // LSB/MSB ordering.
    send_byte(8'hA5);
    send_byte(8'h03);

    // Stalled bits, then back-to-back words.
    for (int i = 0; i < 32; i++) step(1'b0, (i % 2) == 0, 1'($urandom), 1'b0);
    for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 1'($urandom), 1'b0);

    // Partial word, clear on an empty word, clear on the final bit.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'($urandom), 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send_byte(8'h80);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'($urandom), 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1);

    // Counter saturation: ten words in a row.
    send_byte(8'h80);
    for (int i = 0; i < 10; i++) send_byte(8'($urandom));

    // Noise before SYNC.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send_byte(8'hFF);
    send_byte(8'h80);
    send_byte(8'h3C);

    // Random traffic with occasional clear and reset.
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 299) == 0, $urandom_range(0, 9) < 7,
           1'($urandom), $urandom_range(0, 39) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
